mux_nto1_arb: RTL

- Parametrised registered N-to-1 channel multiplexer; successor to the fixed 8:1 mux.
- Each input channel has a valid/ready handshake. The output stage is one registered slot with valid/ready.
- Two selection modes: FIXED, where software picks the channel, and RR, a work-conserving round-robin among valid channels.
- Sits between N producer channels and a single consumer. Doubles as the DUT for the mux testbench environment.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mux_nto1_arb.sv | 78 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the N-to-1 registered channel mux.
package mux_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

  localparam int N_DEF = 8;
  localparam int W_DEF = 8;

  // Width of a channel index for an n-channel mux.
  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps;
// the first requesting channel wins.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = N_DEF,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  // Scan from the farthest candidate down to the nearest, so the nearest
  // requester after ptr overrides any later one.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_arb.sv
// Registered N-to-1 channel mux with FIXED (software select) and
// work-conserving round-robin selection, valid/ready on every side.
module mux_nto1_arb
  import mux_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int W     = W_DEF,
  localparam int SEL_W = sel_w(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_in,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic [N-1:0]        in_valid,
  input  logic [N-1:0][W-1:0] in_data,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);

  mux_mode_e        mode;
  logic [SEL_W-1:0] rr_ptr;
  logic             rr_valid, fx_valid, gnt_valid;
  logic [SEL_W-1:0] rr_idx, fx_idx, gnt_idx;
  logic             load_en, xfer;
  logic [N-1:0]     onehot;

  assign mode = mux_mode_e'(mode_in);

  rr_arbiter #(.N(N)) u_rr (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Fixed select: compare against every legal index so an out-of-range
  // sel_in simply never matches.
  always_comb begin
    fx_valid = 1'b0;
    fx_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_in == SEL_W'(i) && in_valid[i]) begin
        fx_valid = 1'b1;
        fx_idx   = SEL_W'(i);
      end
    end
  end

  assign gnt_valid = (mode == MODE_RR) ? rr_valid : fx_valid;
  assign gnt_idx   = (mode == MODE_RR) ? rr_idx   : fx_idx;

  // Slot can refill in the same cycle it drains.
  assign load_en  = !out_valid || out_ready;
  assign xfer     = gnt_valid && load_en && !rst;
  assign onehot   = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
  assign in_ready = xfer ? onehot : '0;

  // Output slot and round-robin pointer; data only moves on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= SEL_W'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx];
      out_sel   <= gnt_idx;
      if (mode == MODE_RR) rr_ptr <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
